// File: rtl/e203_exu_wbck_sched_if.sv
// Write-back scheduler signal bundle: ALU and long-pipe requests, OITF retire
// handshake and the shared regfile write port.
interface e203_exu_wbck_sched_if #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int ITAG_W  = 2
);
    logic                alu_wbck_i_valid;
    logic                alu_wbck_i_ready;
    logic [XLEN-1:0]     alu_wbck_i_wdat;
    logic [RFIDX_W-1:0]  alu_wbck_i_rdidx;
    logic                alu_wbck_i_itag_vld;
    logic [ITAG_W-1:0]   alu_wbck_i_itag;
    logic                alu_wbck_i_csr;

    logic                longp_wbck_i_valid;
    logic                longp_wbck_i_ready;
    logic [XLEN-1:0]     longp_wbck_i_wdat;
    logic [RFIDX_W-1:0]  longp_wbck_i_rdidx;
    logic [ITAG_W-1:0]   longp_wbck_i_itag;

    logic                oitf_empty;
    logic [ITAG_W-1:0]   oitf_ret_ptr;
    logic                oitf_ret_ena;

    logic                rf_wbck_o_valid;
    logic                rf_wbck_o_ready;
    logic [XLEN-1:0]     rf_wbck_o_wdat;
    logic [RFIDX_W-1:0]  rf_wbck_o_rdidx;
    logic                wbck_busy;

    modport master (
        output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
               alu_wbck_i_itag_vld, alu_wbck_i_itag, alu_wbck_i_csr,
        input  alu_wbck_i_ready,
        output longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_rdidx,
               longp_wbck_i_itag,
        input  longp_wbck_i_ready,
        output oitf_empty, oitf_ret_ptr,
        input  oitf_ret_ena,
        input  rf_wbck_o_valid, rf_wbck_o_wdat, rf_wbck_o_rdidx, wbck_busy,
        output rf_wbck_o_ready
    );

    modport slave (
        input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
               alu_wbck_i_itag_vld, alu_wbck_i_itag, alu_wbck_i_csr,
        output alu_wbck_i_ready,
        input  longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_rdidx,
               longp_wbck_i_itag,
        output longp_wbck_i_ready,
        input  oitf_empty, oitf_ret_ptr,
        output oitf_ret_ena,
        output rf_wbck_o_valid, rf_wbck_o_wdat, rf_wbck_o_rdidx, wbck_busy,
        input  rf_wbck_o_ready
    );
endinterface

// File: rtl/e203_exu_wbck_sched.sv
// Shares the single regfile write port between ALU and long-pipe write-back,
// honouring OITF order, ALU priority and a long-pipe anti-starvation counter.
module e203_exu_wbck_sched #(
    parameter int XLEN       = 32,
    parameter int RFIDX_W    = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    e203_exu_wbck_sched_if.slave    wb
);
    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e               r_state;
    logic [3:0]           r_starve_cnt;
    logic [XLEN-1:0]      r_wdat;
    logic [RFIDX_W-1:0]   r_rdidx;

    logic w_alu_elig;
    logic w_longp_elig;
    logic w_can_load;
    logic w_force;
    logic w_grant_longp;
    logic w_grant_alu;
    logic w_grant_any;

    // Eligibility and arbitration; grants are suppressed while in reset
    always_comb begin
        w_alu_elig    = wb.alu_wbck_i_valid &
                        (~wb.alu_wbck_i_itag_vld |
                         (~wb.oitf_empty & (wb.alu_wbck_i_itag == wb.oitf_ret_ptr)));
        w_longp_elig  = wb.longp_wbck_i_valid & ~wb.oitf_empty &
                        (wb.longp_wbck_i_itag == wb.oitf_ret_ptr);
        w_can_load    = (r_state == ST_EMPTY) | wb.rf_wbck_o_ready;
        w_force       = w_longp_elig & (r_starve_cnt >= LP_STARVE_MAX);
        w_grant_longp = ~rst & w_can_load & w_longp_elig & (w_force | ~w_alu_elig);
        w_grant_alu   = ~rst & w_can_load & w_alu_elig & ~w_grant_longp;
        w_grant_any   = w_grant_longp | w_grant_alu;
    end

    // Output stage FSM, write-port data registers and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_EMPTY;
            r_starve_cnt <= 4'd0;
            r_wdat       <= {XLEN{1'b0}};
            r_rdidx      <= {RFIDX_W{1'b0}};
        end else begin
            case (r_state)
                ST_EMPTY: r_state <= w_grant_any ? ST_FULL : ST_EMPTY;
                // A grant while draining reloads in place, giving zero-bubble back-to-back writes
                ST_FULL:  r_state <= (wb.rf_wbck_o_ready & ~w_grant_any) ? ST_EMPTY : ST_FULL;
                default:  r_state <= ST_EMPTY;
            endcase

            if (w_grant_longp) begin
                r_wdat  <= wb.longp_wbck_i_wdat;
                r_rdidx <= wb.longp_wbck_i_rdidx;
            end else if (w_grant_alu) begin
                r_wdat  <= wb.alu_wbck_i_wdat;
                r_rdidx <= wb.alu_wbck_i_rdidx;
            end else begin
                r_wdat  <= r_wdat;
                r_rdidx <= r_rdidx;
            end

            // Counts lost cycles even when the output stage is stalled
            if (w_grant_longp | ~w_longp_elig) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != 4'hF) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end
    end

    assign wb.alu_wbck_i_ready   = w_grant_alu;
    assign wb.longp_wbck_i_ready = w_grant_longp;
    // Retire fires at acceptance; CSR ops and untracked ALU ops do not retire
    assign wb.oitf_ret_ena       = w_grant_longp |
                                   (w_grant_alu & wb.alu_wbck_i_itag_vld & ~wb.alu_wbck_i_csr);
    assign wb.rf_wbck_o_valid    = (r_state == ST_FULL);
    assign wb.wbck_busy          = (r_state == ST_FULL);
    assign wb.rf_wbck_o_wdat     = r_wdat;
    assign wb.rf_wbck_o_rdidx    = r_rdidx;
endmodule

// File: tb/tb_e203_exu_wbck_sched.sv
// Scoreboard bench for the write-back scheduler: a queue-based reference model
// predicts grants, retire pulses and regfile writes; a negedge monitor checks writes.
module tb_e203_exu_wbck_sched;
    localparam int STARVE_MAX = 4;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  r;
    } wr_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    wr_t  q[$];
    int   g_now;
    int   streak;
    logic last_ga;
    logic last_gl;
    logic alu_pend;
    logic longp_pend;

    e203_exu_wbck_sched_if #(.XLEN(32), .RFIDX_W(5), .ITAG_W(2)) wb ();

    e203_exu_wbck_sched #(.XLEN(32), .RFIDX_W(5), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wb.alu_wbck_i_valid    = 1'b0;
        wb.alu_wbck_i_wdat     = 32'd0;
        wb.alu_wbck_i_rdidx    = 5'd0;
        wb.alu_wbck_i_itag_vld = 1'b0;
        wb.alu_wbck_i_itag     = 2'd0;
        wb.alu_wbck_i_csr      = 1'b0;
        wb.longp_wbck_i_valid  = 1'b0;
        wb.longp_wbck_i_wdat   = 32'd0;
        wb.longp_wbck_i_rdidx  = 5'd0;
        wb.longp_wbck_i_itag   = 2'd0;
        wb.oitf_empty          = 1'b1;
        wb.oitf_ret_ptr        = 2'd0;
        wb.rf_wbck_o_ready     = 1'b1;
    endtask

    // Reference model: one call per cycle after inputs are set
    task automatic check_comb();
        logic ae, le, can_load, gl, ga, ret;
        #1;
        if (rst) begin
            q.delete();
            g_now   = 0;
            streak  = 0;
            last_ga = 1'b0;
            last_gl = 1'b0;
            chk1("rst_alu_ready", wb.alu_wbck_i_ready, 1'b0);
            chk1("rst_longp_ready", wb.longp_wbck_i_ready, 1'b0);
            chk1("rst_ret_ena", wb.oitf_ret_ena, 1'b0);
        end else begin
            ae = wb.alu_wbck_i_valid && (!wb.alu_wbck_i_itag_vld ||
                 (!wb.oitf_empty && wb.alu_wbck_i_itag == wb.oitf_ret_ptr));
            le = wb.longp_wbck_i_valid && !wb.oitf_empty &&
                 wb.longp_wbck_i_itag == wb.oitf_ret_ptr;
            assert (!(ae && le && wb.alu_wbck_i_itag_vld)) else $error("tag conflict in stimulus");
            can_load = (q.size() == 0) || wb.rf_wbck_o_ready;
            gl  = can_load && le && (streak >= STARVE_MAX || !ae);
            ga  = can_load && ae && !gl;
            ret = gl || (ga && wb.alu_wbck_i_itag_vld && !wb.alu_wbck_i_csr);
            chk1("alu_ready", wb.alu_wbck_i_ready, ga);
            chk1("longp_ready", wb.longp_wbck_i_ready, gl);
            chk1("oitf_ret_ena", wb.oitf_ret_ena, ret);
            if (gl) q.push_back('{d: wb.longp_wbck_i_wdat, r: wb.longp_wbck_i_rdidx});
            else if (ga) q.push_back('{d: wb.alu_wbck_i_wdat, r: wb.alu_wbck_i_rdidx});
            g_now = (gl || ga) ? 1 : 0;
            if (le && !gl) streak = (streak < 15) ? streak + 1 : 15;
            else streak = 0;
            last_ga = ga;
            last_gl = gl;
        end
    endtask

    // Monitor: compare the presented write against the oldest expected entry
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            logic exp_full;
            exp_full = ((q.size() - g_now) > 0);
            chk1("rf_valid", wb.rf_wbck_o_valid, exp_full);
            chk1("wbck_busy", wb.wbck_busy, exp_full);
            if (exp_full && wb.rf_wbck_o_valid) begin
                chk32("rf_wdat", wb.rf_wbck_o_wdat, q[0].d);
                chk32("rf_rdidx", 32'(wb.rf_wbck_o_rdidx), 32'(q[0].r));
                if (wb.rf_wbck_o_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; g_now = 0; streak = 0;
        last_ga = 1'b0; last_gl = 1'b0; alu_pend = 1'b0; longp_pend = 1'b0;
        rst = 1'b1;
        idle();
        next(); check_comb();
        next();
        chk1("reset_valid", wb.rf_wbck_o_valid, 1'b0);
        chk1("reset_busy", wb.wbck_busy, 1'b0);
        chk32("reset_wdat", wb.rf_wbck_o_wdat, 32'd0);
        chk32("reset_rdidx", 32'(wb.rf_wbck_o_rdidx), 32'd0);
        rst = 1'b0;
        check_comb();

        // ALU only, untracked
        next(); idle();
        wb.alu_wbck_i_valid = 1'b1; wb.alu_wbck_i_wdat = 32'h1234; wb.alu_wbck_i_rdidx = 5'd5;
        check_comb();
        chk1("t1_alu_ready", wb.alu_wbck_i_ready, 1'b1);
        chk1("t1_ret", wb.oitf_ret_ena, 1'b0);
        next(); idle(); check_comb();
        chk1("t1_valid", wb.rf_wbck_o_valid, 1'b1);
        chk32("t1_wdat", wb.rf_wbck_o_wdat, 32'h1234);
        chk32("t1_rdidx", 32'(wb.rf_wbck_o_rdidx), 32'd5);

        // ALU tracked: wait for OITF order, then CSR variant
        next(); idle();
        wb.oitf_empty = 1'b0; wb.oitf_ret_ptr = 2'd1;
        wb.alu_wbck_i_valid = 1'b1; wb.alu_wbck_i_itag_vld = 1'b1; wb.alu_wbck_i_itag = 2'd2;
        wb.alu_wbck_i_wdat = 32'h2222; wb.alu_wbck_i_rdidx = 5'd2;
        check_comb();
        chk1("t2_hold", wb.alu_wbck_i_ready, 1'b0);
        next(); wb.oitf_ret_ptr = 2'd2; check_comb();
        chk1("t2_grant", wb.alu_wbck_i_ready, 1'b1);
        chk1("t2_ret", wb.oitf_ret_ena, 1'b1);
        next(); wb.alu_wbck_i_csr = 1'b1; wb.alu_wbck_i_wdat = 32'h3333; check_comb();
        chk1("t2_csr_grant", wb.alu_wbck_i_ready, 1'b1);
        chk1("t2_csr_ret", wb.oitf_ret_ena, 1'b0);

        // Both eligible every cycle: longp forced on the 5th and 10th cycles
        for (int cyc = 0; cyc < 10; cyc++) begin
            next(); idle();
            wb.oitf_empty = 1'b0; wb.oitf_ret_ptr = 2'd3;
            wb.alu_wbck_i_valid = 1'b1; wb.alu_wbck_i_wdat = $urandom; wb.alu_wbck_i_rdidx = 5'(cyc);
            wb.longp_wbck_i_valid = 1'b1; wb.longp_wbck_i_itag = 2'd3;
            wb.longp_wbck_i_wdat = $urandom; wb.longp_wbck_i_rdidx = 5'(cyc + 16);
            check_comb();
            chk1("t3_longp_turn", wb.longp_wbck_i_ready, (cyc == 4 || cyc == 9));
            chk1("t3_alu_turn", wb.alu_wbck_i_ready, !(cyc == 4 || cyc == 9));
        end

        // Output stall holds data; release drains and reloads in one cycle
        next(); idle();
        wb.alu_wbck_i_valid = 1'b1; wb.alu_wbck_i_wdat = 32'hA5A5; wb.alu_wbck_i_rdidx = 5'd7;
        check_comb();
        for (int cyc = 0; cyc < 4; cyc++) begin
            next(); idle();
            wb.rf_wbck_o_ready = (cyc == 3);
            wb.oitf_empty = 1'b0; wb.oitf_ret_ptr = 2'd0;
            wb.alu_wbck_i_valid = 1'b1; wb.alu_wbck_i_wdat = 32'h1111; wb.alu_wbck_i_rdidx = 5'd3;
            wb.longp_wbck_i_valid = 1'b1; wb.longp_wbck_i_itag = 2'd0; wb.longp_wbck_i_wdat = 32'h4444;
            check_comb();
            chk32("t4_hold_wdat", wb.rf_wbck_o_wdat, 32'hA5A5);
            chk32("t4_hold_rdidx", 32'(wb.rf_wbck_o_rdidx), 32'd7);
            chk1("t4_alu_ready", wb.alu_wbck_i_ready, (cyc == 3));
            chk1("t4_ret", wb.oitf_ret_ena, 1'b0);
        end
        next(); idle(); check_comb();
        chk1("t4_reload_valid", wb.rf_wbck_o_valid, 1'b1);
        chk32("t4_reload_wdat", wb.rf_wbck_o_wdat, 32'h1111);

        // Empty OITF blocks longp but not untracked ALU
        for (int cyc = 0; cyc < 4; cyc++) begin
            next(); idle();
            wb.longp_wbck_i_valid = 1'b1; wb.longp_wbck_i_wdat = 32'h5555;
            wb.alu_wbck_i_valid = (cyc == 2); wb.alu_wbck_i_wdat = 32'h6666;
            check_comb();
            chk1("t5_longp_blocked", wb.longp_wbck_i_ready, 1'b0);
            chk1("t5_alu", wb.alu_wbck_i_ready, (cyc == 2));
        end

        // Reset while full with longp starving: state and counter cleared
        next(); idle();
        wb.alu_wbck_i_valid = 1'b1; wb.alu_wbck_i_wdat = 32'hBEEF; wb.alu_wbck_i_rdidx = 5'd9;
        check_comb();
        for (int cyc = 0; cyc < 6; cyc++) begin
            next(); idle();
            rst = (cyc == 5);
            wb.rf_wbck_o_ready = 1'b0; wb.oitf_empty = 1'b0; wb.oitf_ret_ptr = 2'd1;
            wb.alu_wbck_i_valid = 1'b1; wb.alu_wbck_i_wdat = 32'h7777;
            wb.longp_wbck_i_valid = 1'b1; wb.longp_wbck_i_itag = 2'd1; wb.longp_wbck_i_wdat = 32'h8888;
            check_comb();
        end
        next(); rst = 1'b0; idle(); check_comb();
        chk1("t6_valid", wb.rf_wbck_o_valid, 1'b0);
        chk1("t6_busy", wb.wbck_busy, 1'b0);
        chk32("t6_wdat", wb.rf_wbck_o_wdat, 32'd0);
        chk32("t6_rdidx", 32'(wb.rf_wbck_o_rdidx), 32'd0);
        next(); idle();
        wb.oitf_empty = 1'b0; wb.oitf_ret_ptr = 2'd1;
        wb.alu_wbck_i_valid = 1'b1; wb.alu_wbck_i_wdat = 32'h9999;
        wb.longp_wbck_i_valid = 1'b1; wb.longp_wbck_i_itag = 2'd1; wb.longp_wbck_i_wdat = 32'hAAAA;
        check_comb();
        chk1("t6_cnt_cleared", wb.alu_wbck_i_ready, 1'b1);
        next(); idle(); check_comb();

        // Randomized traffic with held requests until granted
        alu_pend = 1'b0; longp_pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            next();
            rst = ($urandom_range(0, 149) == 0);
            if (!longp_pend) begin
                wb.longp_wbck_i_valid = ($urandom_range(0, 2) != 0);
                wb.longp_wbck_i_wdat  = $urandom;
                wb.longp_wbck_i_rdidx = 5'($urandom);
                wb.longp_wbck_i_itag  = 2'($urandom);
            end
            if (!alu_pend) begin
                wb.alu_wbck_i_valid    = ($urandom_range(0, 2) != 0);
                wb.alu_wbck_i_wdat     = $urandom;
                wb.alu_wbck_i_rdidx    = 5'($urandom);
                wb.alu_wbck_i_itag_vld = ($urandom_range(0, 1) == 1);
                wb.alu_wbck_i_itag     = 2'($urandom);
                wb.alu_wbck_i_csr      = ($urandom_range(0, 5) == 0);
            end
            if (wb.alu_wbck_i_valid && wb.alu_wbck_i_itag_vld && wb.longp_wbck_i_valid &&
                wb.alu_wbck_i_itag == wb.longp_wbck_i_itag) begin
                if (!alu_pend) wb.alu_wbck_i_itag = wb.longp_wbck_i_itag + 2'd1;
                else wb.longp_wbck_i_itag = wb.alu_wbck_i_itag + 2'd1;
            end
            wb.oitf_empty      = ($urandom_range(0, 5) == 0);
            wb.oitf_ret_ptr    = 2'($urandom);
            wb.rf_wbck_o_ready = ($urandom_range(0, 3) != 0);
            check_comb();
            alu_pend   = wb.alu_wbck_i_valid && !last_ga;
            longp_pend = wb.longp_wbck_i_valid && !last_gl;
        end

        next(); rst = 1'b0; idle(); check_comb();
        next(); idle(); check_comb();
        next(); idle(); check_comb();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/e203_exu_wbck_sched.md
Name: e203_exu_wbck_sched

Overview:
- Write-back scheduler that shares the single integer regfile write port between two requesters: the ALU write-back path and the long-pipe (LSU/muldiv) write-back path.
- Enforces OITF retirement order for OITF-tracked instructions.
- Arbitrates with ALU priority plus a long-pipe anti-starvation counter.
- Drives a registered, one-entry write-port stage and generates the OITF retire pulse.

Parameters:
- XLEN, 32, write data width (E203_XLEN)
- RFIDX_W, 5, register index width (E203_RFIDX_WIDTH)
- ITAG_W, 2, OITF tag width (E203_ITAG_WIDTH)
- STARVE_MAX, 4, consecutive cycles an eligible long-pipe request may lose before being forced; range 1..15

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- alu_wbck_i_valid  input  1  ALU write-back request
- alu_wbck_i_ready  output  1  ALU request accepted this cycle
- alu_wbck_i_wdat  input  XLEN  ALU result
- alu_wbck_i_rdidx  input  RFIDX_W  destination register
- alu_wbck_i_itag_vld  input  1  instruction occupies an OITF entry
- alu_wbck_i_itag  input  ITAG_W  OITF tag (valid when itag_vld=1)
- alu_wbck_i_csr  input  1  CSR op; writes the regfile but never retires OITF
- longp_wbck_i_valid  input  1  long-pipe write-back request (always OITF-tracked)
- longp_wbck_i_ready  output  1  long-pipe request accepted this cycle
- longp_wbck_i_wdat  input  XLEN  long-pipe result
- longp_wbck_i_rdidx  input  RFIDX_W  destination register
- longp_wbck_i_itag  input  ITAG_W  OITF tag
- oitf_empty  input  1  OITF holds no entries
- oitf_ret_ptr  input  ITAG_W  tag of oldest OITF entry
- oitf_ret_ena  output  1  retire oldest OITF entry (one-cycle pulse)
- rf_wbck_o_valid  output  1  registered regfile write valid
- rf_wbck_o_ready  input  1  regfile accepts write
- rf_wbck_o_wdat  output  XLEN  registered write data
- rf_wbck_o_rdidx  output  RFIDX_W  registered write index
- wbck_busy  output  1  output stage holds data

Behaviour:
- Eligibility (combinational):
  - alu_elig = alu_valid & (~itag_vld | (~oitf_empty & alu_itag==oitf_ret_ptr)).
  - longp_elig = longp_valid & ~oitf_empty & longp_itag==oitf_ret_ptr.
- Output stage, states EMPTY/FULL:
  - can_load = EMPTY | (FULL & rf_wbck_o_ready).
  - FULL with ready=0: hold data and index stable; valid stays 1.
  - FULL with ready=1 and no grant: go to EMPTY.
  - FULL with ready=1 and a grant: reload, stay FULL (back-to-back, zero bubble).
  - EMPTY with a grant: go to FULL next cycle.
  - Latency: request to rf_wbck_o_valid is 1 cycle.
- Arbitration, only when can_load:
  - force = longp_elig & (starve_cnt >= STARVE_MAX).
  - grant_longp = longp_elig & (force | ~alu_elig).
  - grant_alu = alu_elig & ~grant_longp.
  - At most one grant per cycle.
  - *_ready = corresponding grant. Ineligible or losing requests see ready=0 and must hold.
- Starvation counter (4-bit, saturating at 15):
  - Clear when grant_longp or ~longp_elig.
  - Increment when longp_elig & ~grant_longp, including cycles blocked by a stalled output stage.
- OITF retire:
  - oitf_ret_ena = grant_longp | (grant_alu & alu_itag_vld & ~alu_csr).
  - Asserted in the grant (acceptance) cycle, not at the regfile write.
  - Both requesters can never be eligible with itag_vld=1 and the same tag; the bench checks this with an assertion.
- Simultaneous events: the output stage draining and loading in the same cycle is legal; the new data appears next cycle with no gap.
- Reset, including mid-operation:
  - State = EMPTY; starve_cnt = 0.
  - rf_wbck_o_valid = 0, wbck_busy = 0.
  - rf_wbck_o_wdat and rf_wbck_o_rdidx = 0.
  - oitf_ret_ena = 0, all ready outputs = 0 during the reset cycle.
  - Held data is discarded.
- Width rules: equality compare on ITAG_W bits, wraps naturally. No arithmetic on data.

Test Plan:
- ALU only, itag_vld=0, wdat=0x1234, rdidx=5, ready=1 -> alu ready same cycle; next cycle rf valid with 0x1234/5; oitf_ret_ena=0.
- ALU itag_vld=1, itag=2, oitf_ret_ptr=1 -> alu_ready=0 held. Then ret_ptr=2 -> grant and oitf_ret_ena=1 that cycle. Same flow with csr=1 -> grant but oitf_ret_ena=0.
- Both eligible every cycle (ALU itag_vld=0, longp itag==ret_ptr=3), STARVE_MAX=4 -> ALU wins 4 cycles, longp granted on cycle 5, counter then resets to 0.
- rf_wbck_o_ready=0 for 3 cycles while FULL with 0xA5A5/7 -> outputs held stable, no grants, no oitf_ret_ena. Ready=1 with a pending request -> drain and reload in the same cycle.
- oitf_empty=1 with longp_valid=1 -> longp never granted; an ALU request with itag_vld=0 is still granted.
- rst asserted while FULL with a longp request pending -> next cycle rf_wbck_o_valid=0, starve_cnt=0, no ready. Normal operation resumes the cycle after rst deasserts.
